// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: word size, NOP encoding, reset PC and the buffered entry layout.
package riscv_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous power-of-two FIFO with flush and occupancy count; push on full is accepted only with a pop.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Flush wins over push and pop in the same cycle.
  always_comb begin
    empty     = (count_r == {CNT_W{1'b0}});
    full      = (count_r == FULL_CNT);
    do_pop_s  = pop && !empty && !flush;
    do_push_s = push && !flush && (!full || do_pop_s);
    count     = count_r;
    dout      = mem_r[rd_ptr_r];
  end

  // Read/write pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited in-order imem requests, buffers tagged
// responses for IF/ID and discards stale responses after a redirect.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 4,
  parameter int              CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_stall,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);

  localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

  logic [XLEN-1:0]  pc_r;
  logic [CNT_W-1:0] drop_cnt_r;
  logic [CNT_W-1:0] drop_cnt_nxt_s;
  fetch_state_e     state_r;
  fetch_state_e     state_nxt_s;
  logic [CNT_W-1:0] outstanding_s;
  logic [CNT_W-1:0] fifo_count_s;
  logic [CNT_W:0]   occupancy_s;
  logic             credit_s;
  logic             req_fire_s;
  logic             rsp_drop_s;
  logic             push_s;
  logic             pop_s;
  logic [XLEN-1:0]  tag_s;
  fetch_entry_t     rsp_entry_s;
  fetch_entry_t     head_s;
  logic             empty_s;
  logic             data_full_s;
  logic             tag_empty_s;
  logic             tag_full_s;
  logic             unused_s;

  // The tag queue depth equals the number of requests in flight, so its count is "outstanding".
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_fire_s),
    .din   (pc_r),
    .pop   (imem_rsp_valid),
    .flush (1'b0),
    .dout  (tag_s),
    .count (outstanding_s),
    .empty (tag_empty_s),
    .full  (tag_full_s)
  );

  fetch_fifo #(.WIDTH(2 * XLEN), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_data_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .din   (rsp_entry_s),
    .pop   (pop_s),
    .flush (redirect_valid),
    .dout  (head_s),
    .count (fifo_count_s),
    .empty (empty_s),
    .full  (data_full_s)
  );

  // State register: PC, stale-response counter and drain state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r       <= RESET_PC;
      drop_cnt_r <= {CNT_W{1'b0}};
      state_r    <= FETCH_RUN;
    end else begin
      drop_cnt_r <= drop_cnt_nxt_s;
      state_r    <= state_nxt_s;
      if (redirect_valid)  pc_r <= align_word(redirect_pc);
      else if (req_fire_s) pc_r <= pc_r + 32'd4;
    end
  end

  // Next state: a redirect re-arms the drop count from everything still in flight
  always_comb begin
    drop_cnt_nxt_s = drop_cnt_r;
    if (redirect_valid) begin
      drop_cnt_nxt_s = outstanding_s - CNT_W'(imem_rsp_valid);
    end else if (rsp_drop_s) begin
      drop_cnt_nxt_s = drop_cnt_r - CNT_W'(1'b1);
    end else begin
      drop_cnt_nxt_s = drop_cnt_r;
    end
    if (drop_cnt_nxt_s == {CNT_W{1'b0}}) state_nxt_s = FETCH_RUN;
    else                                 state_nxt_s = FETCH_DRAIN;
  end

  // Outputs: credit-limited request, response filter, FIFO head presentation
  always_comb begin
    occupancy_s    = {1'b0, outstanding_s} + {1'b0, fifo_count_s};
    credit_s       = occupancy_s < CREDIT_LIMIT;
    imem_req_valid = rst_n && !redirect_valid && credit_s;
    imem_req_addr  = pc_r;
    req_fire_s     = imem_req_valid && imem_req_ready;
    rsp_drop_s     = imem_rsp_valid && (redirect_valid || (state_r == FETCH_DRAIN));
    push_s         = imem_rsp_valid && !rsp_drop_s;
    pop_s          = !empty_s && !id_stall && !redirect_valid;
    rsp_entry_s    = '{pc: tag_s, instr: imem_rsp_data};
    instr_valid    = !empty_s;
    if (empty_s) begin
      instr    = NOP_INSTR;
      instr_pc = {XLEN{1'b0}};
    end else begin
      instr    = head_s.instr;
      instr_pc = head_s.pc;
    end
    unused_s = &{1'b0, data_full_s, tag_empty_s, tag_full_s};
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench: in-order memory model with variable latency and a queue-based fetch model.
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  localparam int D     = 4;
  localparam int CNT_W = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        instr_valid;
  logic [31:0] instr, instr_pc;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_stall(id_stall),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc)
  );

  typedef struct { logic [31:0] pc; bit stale; } inf_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mem_t;

  inf_t inf_q[$];
  ent_t fifo_q[$];
  mem_t mem_q[$];
  logic [31:0] m_pc;
  int vectors, fails, cyc, lat, last_due;
  bit rand_lat;
  logic [31:0] salt;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a ^ salt) * 32'h9E37_79B1;
  endfunction
  function automatic bit e_req_valid();
    return (rst_n === 1'b1) && (redirect_valid === 1'b0) && ((inf_q.size() + fifo_q.size()) < D);
  endfunction
  function automatic bit e_valid();
    return fifo_q.size() > 0;
  endfunction
  function automatic logic [31:0] e_instr();
    return (fifo_q.size() > 0) ? fifo_q[0].data : NOP_INSTR;
  endfunction
  function automatic logic [31:0] e_pc();
    return (fifo_q.size() > 0) ? fifo_q[0].pc : 32'h0;
  endfunction
  function automatic int stale_cnt();
    int n = 0;
    foreach (inf_q[i]) if (inf_q[i].stale) n++;
    return n;
  endfunction

  task automatic model_clear();
    inf_q.delete(); fifo_q.delete(); mem_q.delete();
    m_pc = 32'h0; last_due = 0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Advance one clock: update the reference model and the memory from this cycle's inputs.
  task automatic cycle();
    inf_t e;
    bit keep, mfire;
    int d;
    keep  = 1'b0;
    mfire = e_req_valid() && (imem_req_ready === 1'b1);
    if (imem_rsp_valid) begin
      if (inf_q.size() == 0) begin
        vectors++; fails++;
        $display("FAIL rsp_without_request: response with %0d in flight, want >=1", inf_q.size());
      end else begin
        e = inf_q.pop_front();
        keep = !redirect_valid && !e.stale;
      end
    end
    if (!redirect_valid && fifo_q.size() > 0 && !id_stall) void'(fifo_q.pop_front());
    if (keep) begin
      vectors++;
      if (fifo_q.size() >= D) begin
        fails++;
        $display("FAIL fifo_overflow: push at occupancy %0d, want <%0d", fifo_q.size(), D);
      end
      fifo_q.push_back('{pc: e.pc, data: memfn(e.pc)});
    end
    if (redirect_valid) begin
      fifo_q.delete();
      foreach (inf_q[i]) inf_q[i].stale = 1'b1;
      m_pc = {redirect_pc[31:2], 2'b00};
    end else if (mfire) begin
      inf_q.push_back('{pc: m_pc, stale: 1'b0});
      m_pc = m_pc + 32'd4;
    end
    if (imem_rsp_valid && mem_q.size() > 0) void'(mem_q.pop_front());
    if (imem_req_valid === 1'b1 && imem_req_ready) begin
      d = cyc + (rand_lat ? int'($urandom_range(1, 4)) : lat);
      if (d < last_due) d = last_due;
      last_due = d;
      mem_q.push_back('{addr: imem_req_addr, due: d});
    end
    @(posedge clk);
    #1;
    cyc++;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = memfn(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0; imem_rsp_data = $urandom;
    end
  endtask

  task automatic quiesce();
    imem_req_ready = 1'b0; id_stall = 1'b0; redirect_valid = 1'b0;
    repeat (14) begin #2; cycle(); end
  endtask

  task automatic test_reset();
    #3;
    vectors++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    vectors++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
    vectors++; if (instr !== NOP_INSTR) begin fails++; $display("FAIL reset_instr: got %h want %h", instr, NOP_INSTR); end
    vectors++; if (instr_pc !== 32'h0) begin fails++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
    vectors++; if (imem_req_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", imem_req_addr); end
    apply_reset();
  endtask

  task automatic test_stream();
    apply_reset();
    imem_req_ready = 1'b1; id_stall = 1'b0; redirect_valid = 1'b0; lat = 1;
    for (int i = 0; i < 20; i++) begin
      #2;
      vectors++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * i)) begin
        fails++; $display("FAIL stream_req[%0d]: got %b/%h want 1/%h", i, imem_req_valid, imem_req_addr, 32'(4 * i));
      end
      if (i >= 2) begin
        vectors++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * (i - 2)) || instr !== memfn(32'(4 * (i - 2)))) begin
          fails++; $display("FAIL stream_instr[%0d]: got %b %h %h want 1 %h %h", i, instr_valid, instr_pc, instr,
                            32'(4 * (i - 2)), memfn(32'(4 * (i - 2))));
        end
      end
      cycle();
    end
  endtask

  task automatic test_stall();
    int fires;
    logic [31:0] start_pc;
    quiesce();
    lat = 1; imem_req_ready = 1'b1; id_stall = 1'b1; fires = 0; start_pc = m_pc;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (imem_req_valid && imem_req_ready) fires++;
      if (instr_valid === 1'b1) begin
        vectors++;
        if (instr_pc !== start_pc) begin fails++; $display("FAIL stall_hold[%0d]: got %h want %h", i, instr_pc, start_pc); end
      end
      cycle();
    end
    vectors++; if (fires !== D) begin fails++; $display("FAIL stall_requests: got %0d want %0d", fires, D); end
    id_stall = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #2;
      vectors++;
      if (instr_valid !== e_valid() || instr_pc !== e_pc() || instr !== e_instr()) begin
        fails++; $display("FAIL stall_resume[%0d]: got %b %h %h want %b %h %h", i, instr_valid, instr_pc, instr, e_valid(), e_pc(), e_instr());
      end
      cycle();
    end
  endtask

  task automatic test_redirect_drain();
    bit seen;
    quiesce();
    lat = 3; imem_req_ready = 1'b1;
    repeat (2) begin #2; cycle(); end
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    #2;
    vectors++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL drain_redirect_req: got %b want 0", imem_req_valid); end
    cycle();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    vectors++; if (dut.drop_cnt_r !== 3'd2) begin fails++; $display("FAIL drain_drop_cnt: got %0d want 2", dut.drop_cnt_r); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (!seen && instr_valid === 1'b1) begin
        seen = 1'b1; vectors++;
        if (instr_pc !== 32'h0000_0100) begin fails++; $display("FAIL drain_first_pc: got %h want 00000100", instr_pc); end
      end
      vectors++;
      if (instr_valid !== e_valid() || instr_pc !== e_pc() || instr !== e_instr()) begin
        fails++; $display("FAIL drain_stream[%0d]: got %b %h %h want %b %h %h", i, instr_valid, instr_pc, instr, e_valid(), e_pc(), e_instr());
      end
      cycle();
    end
    if (!seen) begin vectors++; fails++; $display("FAIL drain_timeout: instr_valid got 0 want 1"); end
  endtask

  task automatic test_redirect_with_rsp();
    bit found;
    int exp_drop;
    apply_reset();
    lat = 2; imem_req_ready = 1'b1; id_stall = 1'b0; redirect_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (imem_rsp_valid && mem_q.size() > 0 && mem_q[0].addr == 32'h8) begin found = 1'b1; break; end
      cycle();
    end
    if (!found) begin
      vectors++; fails++; $display("FAIL same_rsp_timeout: response for 00000008 got none want one");
    end else begin
      exp_drop = inf_q.size() - 1;
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
      #1;
      vectors++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL same_rsp_req: got %b want 0", imem_req_valid); end
      cycle();
      redirect_valid = 1'b0;
      vectors++; if (dut.drop_cnt_r !== 3'(exp_drop)) begin fails++; $display("FAIL same_rsp_drop: got %0d want %0d", dut.drop_cnt_r, exp_drop); end
      for (int i = 0; i < 12; i++) begin
        #2;
        vectors++;
        if ((instr_valid === 1'b1 && instr_pc === 32'h8) || instr_pc !== e_pc() || instr !== e_instr()) begin
          fails++; $display("FAIL same_rsp_stream[%0d]: got %b %h %h want %b %h %h", i, instr_valid, instr_pc, instr, e_valid(), e_pc(), e_instr());
        end
        cycle();
      end
    end
  endtask

  task automatic test_ready_toggle();
    bit have_prev;
    logic [31:0] prev;
    int accepts;
    quiesce();
    lat = 1; imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF2;
    #2; cycle();
    redirect_valid = 1'b0; have_prev = 1'b0; accepts = 0; prev = 32'h0;
    for (int i = 0; i < 16; i++) begin
      imem_req_ready = ((i % 4) == 0) || ((i % 4) == 3);
      #2;
      vectors++;
      if (imem_req_addr !== m_pc || imem_req_valid !== e_req_valid()) begin
        fails++; $display("FAIL toggle_addr[%0d]: got %b %h want %b %h", i, imem_req_valid, imem_req_addr, e_req_valid(), m_pc);
      end
      if (imem_req_valid && imem_req_ready) begin
        vectors++;
        if (have_prev ? (imem_req_addr !== prev + 32'd4) : (imem_req_addr !== 32'hFFFF_FFF0)) begin
          fails++; $display("FAIL toggle_seq[%0d]: got %h after %h", i, imem_req_addr, prev);
        end
        prev = imem_req_addr; have_prev = 1'b1; accepts++;
      end
      cycle();
    end
    vectors++; if (accepts !== 8) begin fails++; $display("FAIL toggle_accepts: got %0d want 8", accepts); end
  endtask

  task automatic test_reset_mid();
    lat = 2; imem_req_ready = 1'b1; id_stall = 1'b0; redirect_valid = 1'b0;
    repeat (6) begin #2; cycle(); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== NOP_INSTR || instr_pc !== 32'h0 || imem_req_addr !== 32'h0) begin
      fails++; $display("FAIL midreset_outputs: got %b %b %h %h %h want 0 0 %h 0 0", imem_req_valid, instr_valid, instr, instr_pc, imem_req_addr, NOP_INSTR);
    end
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (i == 0) begin
        vectors++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin fails++; $display("FAIL midreset_restart: got %b %h want 1 0", imem_req_valid, imem_req_addr); end
      end
      vectors++;
      if (instr_valid !== e_valid() || instr_pc !== e_pc() || instr !== e_instr()) begin
        fails++; $display("FAIL midreset_stream[%0d]: got %b %h %h want %b %h %h", i, instr_valid, instr_pc, instr, e_valid(), e_pc(), e_instr());
      end
      cycle();
    end
  endtask

  task automatic test_random();
    bit prev_redir;
    rand_lat = 1'b1; prev_redir = 1'b0;
    for (int i = 0; i < 600; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_stall       = ($urandom_range(0, 3) == 0);
      redirect_valid = prev_redir ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom;
      prev_redir     = redirect_valid;
      #2;
      vectors++;
      if (imem_req_valid !== e_req_valid() || imem_req_addr !== m_pc) begin
        fails++; $display("FAIL rand_req[%0d]: got %b %h want %b %h", i, imem_req_valid, imem_req_addr, e_req_valid(), m_pc);
      end
      vectors++;
      if (instr_valid !== e_valid() || instr_pc !== e_pc() || instr !== e_instr()) begin
        fails++; $display("FAIL rand_instr[%0d]: got %b %h %h want %b %h %h", i, instr_valid, instr_pc, instr, e_valid(), e_pc(), e_instr());
      end
      vectors++;
      if (dut.drop_cnt_r !== 3'(stale_cnt())) begin
        fails++; $display("FAIL rand_drop[%0d]: got %0d want %0d", i, dut.drop_cnt_r, stale_cnt());
      end
      cycle();
    end
    rand_lat = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    vectors = 0; fails = 0; cyc = 0; lat = 1; rand_lat = 1'b0; salt = $urandom;
    rst_n = 1'b0; imem_req_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; id_stall = 1'b0;
    model_clear();
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drain();
    test_redirect_with_rsp();
    test_ready_toggle();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the IF/ID instruction pipeline register.
- Owns the PC and issues in-order word requests to instruction memory using a valid/ready request channel and a valid-only response channel.
- Buffers the returned instructions, tagged with their PC, in a small FIFO and presents them to the IF/ID register.
- Handles redirects from branch/jump resolution by flushing and discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 4, instruction buffer entries (power of two, ≥2); also caps in-flight requests.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of the occupancy, outstanding and drop counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  word-aligned fetch address (current PC).
- imem_rsp_valid  in  1  response data valid; responses are in order, one per accepted request, latency ≥1 cycle.
- imem_rsp_data  in  32  fetched instruction.
- redirect_valid  in  1  control-flow redirect from execute.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- id_stall  in  1  downstream hold; the head entry must not be consumed.
- instr_valid  out  1  head entry valid.
- instr  out  32  head instruction; 32'h0000_0013 (NOP) when instr_valid=0.
- instr_pc  out  32  PC of the head instruction.

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC.
  - FIFO empty; outstanding=0; drop_cnt=0.
  - imem_req_valid=0, instr_valid=0, instr=NOP, instr_pc=0.
- Credit rule: imem_req_valid = !redirect_valid && (outstanding + fifo_count) < FIFO_DEPTH. Both counts are registered values.
- Request accept (req_valid && req_ready):
  - pc <= pc+4 (mod 2^32, wraps silently).
  - outstanding++.
  - A PC FIFO, or equivalent, records the address for tagging the response.
- Response:
  - outstanding-- on every imem_rsp_valid.
  - If drop_cnt>0: drop_cnt-- and the data is discarded.
  - Otherwise push {pc_tag, data} into the FIFO.
  - A push to a full FIFO cannot occur by construction; the bench asserts this.
- Consume: instr_valid = !empty. The head pops when instr_valid && !id_stall. Outputs are driven from the FIFO head with zero added latency.
- Latency: the instruction first appears on instr the cycle after its imem_rsp_valid.
- Push and pop in the same cycle are legal at any occupancy, including full.
- Redirect (has priority over everything):
  - pc <= {redirect_pc[31:2],2'b00}.
  - FIFO flushed; a pop in the same cycle is suppressed.
  - No request is issued that cycle.
  - drop_cnt <= outstanding - imem_rsp_valid.
  - Any response arriving in the same cycle is discarded and is not pushed.
  - outstanding <= outstanding - imem_rsp_valid.
  - Back-to-back redirects: each overwrites pc and recomputes drop_cnt from the current outstanding count.
- Effective state machine:
  - RUN when drop_cnt=0.
  - DRAIN when drop_cnt>0. Requests to the new PC may still issue in DRAIN. The block leaves DRAIN when the last stale response is dropped.
- Reset asserted mid-operation: all state clears immediately. After release, any responses still returning from the memory are the environment's responsibility; the memory is reset together with this block.
- id_stall does not stop requests; credit limiting stops them once the FIFO plus in-flight requests reach FIFO_DEPTH.

Decomposition:
- Shared package (riscv_pkg):
  - XLEN=32
  - NOP_INSTR=32'h0000_0013
  - RESET_PC default
- One sub-module: fetch_fifo.
  - Synchronous FIFO, parameterized width/depth, with push/pop/flush/count.
  - Instantiated twice: once for {pc,instr}, once as the in-flight PC tag queue. Alternatively, a single tag FIFO plus a data FIFO.
- Counter and credit logic stays in instr_fetch_unit.

Test Plan:
- Reset, with imem_req_ready=1 and 1-cycle latency, no stall → requests at 0x0,0x4,0x8…; instr_pc sequence 0x0,0x4,0x8 with matching data; instr_valid continuous from cycle 3.
- id_stall=1 for 10 cycles → exactly FIFO_DEPTH (4) requests issued, then imem_req_valid=0. instr/instr_pc stay at 0x0 throughout; on release the stream resumes in order with no loss or duplication.
- 3-cycle memory latency with 2 requests outstanding, then redirect_pc=0x100 → the 2 stale responses are dropped, the FIFO is flushed, and the next instr_valid shows instr_pc=0x100.
- redirect_valid in the same cycle as imem_rsp_valid for PC 0x8 → the 0x8 data never appears, drop_cnt equals outstanding-1, and the no-request-that-cycle rule is checked.
- imem_req_ready toggling 1,0,0,1 → imem_req_addr holds while ready=0, with no skipped or repeated PC. pc=0xFFFF_FFFC wraps to 0x0.
- rst_n pulsed low mid-stream, asynchronously between edges → outputs go to reset values immediately; fetch restarts at RESET_PC.
